// File: rtl/mips_commit_trace_fifo.sv
// rtl/mips_commit_trace_fifo.sv - in-order commit trace FIFO (GRF/DM writes) with stall and drop accounting
// Optional: define TRACE_DROP_ZERO_EN to discard GRF writes to $0 at the input.
module mips_commit_trace_fifo #(
  parameter int DEPTH        = 16,
  parameter int AFULL_MARGIN = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        grf_we,
  input  logic [31:0] grf_pc,
  input  logic [4:0]  grf_addr,
  input  logic [31:0] grf_wdata,
  input  logic        dm_we,
  input  logic [31:0] dm_pc,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_type,
  output logic [31:0] out_pc,
  output logic [31:0] out_addr,
  output logic [31:0] out_data,
  output logic        stall_req,
  output logic        overflow,
  output logic [15:0] drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0]   FREE_ONE    = (CW+1)'(1);
  localparam logic [CW:0]   FREE_TWO    = (CW+1)'(2);
  localparam logic [CW:0]   FREE_DEPTH  = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] AFULL_LEVEL = CW'(DEPTH - AFULL_MARGIN);

  typedef struct packed {
    logic        etype;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, dm_ptr;
  logic [CW-1:0] count, count_next;
  logic [CW:0]   free;
  logic          grf_v, dm_v, grf_acc, dm_acc, pop;
  logic [1:0]    drops;
  logic [16:0]   drop_sum;
  entry_t        grf_entry, dm_entry, head;

`ifdef TRACE_DROP_ZERO_EN
  assign grf_v = grf_we && (grf_addr != 5'd0);
`else
  assign grf_v = grf_we;
`endif
  assign dm_v = dm_we;

  assign grf_entry = '{etype: 1'b0, pc: grf_pc, addr: {27'd0, grf_addr}, data: grf_wdata};
  assign dm_entry  = '{etype: 1'b1, pc: dm_pc, addr: dm_addr, data: dm_wdata};

  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;

  // A pop at this edge frees a slot that the same edge's pushes may use.
  assign free    = FREE_DEPTH - {1'b0, count} + {{CW{1'b0}}, pop};
  assign grf_acc = grf_v && (free >= FREE_ONE);
  assign dm_acc  = dm_v && (free >= (grf_acc ? FREE_TWO : FREE_ONE));
  assign drops   = {1'b0, grf_v && !grf_acc} + {1'b0, dm_v && !dm_acc};

  assign dm_ptr     = wr_ptr + AW'(grf_acc);
  assign count_next = count + CW'(grf_acc) + CW'(dm_acc) - CW'(pop);
  assign drop_sum   = {1'b0, drop_cnt} + 17'(drops);

  assign head     = mem[rd_ptr];
  assign out_type = out_valid ? head.etype : 1'b0;
  assign out_pc   = out_valid ? head.pc    : 32'd0;
  assign out_addr = out_valid ? head.addr  : 32'd0;
  assign out_data = out_valid ? head.data  : 32'd0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (grf_acc) mem[wr_ptr] <= grf_entry;
      if (dm_acc)  mem[dm_ptr] <= dm_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      stall_req <= 1'b0;
      overflow  <= 1'b0;
      drop_cnt  <= 16'd0;
    end else begin
      rd_ptr    <= rd_ptr + AW'(pop);
      wr_ptr    <= wr_ptr + AW'(grf_acc) + AW'(dm_acc);
      count     <= count_next;
      stall_req <= (count_next >= AFULL_LEVEL);
      if (drops != 2'd0) begin
        overflow <= 1'b1;
        drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
    end
  end

endmodule
